// File: rtl/cpu86_mem_arb_pkg.sv
// Shared types and widths for the cpu86 two-port memory arbiter.
// The dual-issue option is selected with CPU86_MEM_ARB_DUAL_ISSUE_EN.
package cpu86_mem_arb_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 25;
    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned NUM_LANES      = 4;

    typedef enum logic [1:0] {TAG_NONE, TAG_IF, TAG_D} rsp_tag_t;

    // Core-side write request; wmask is active-low, bit 3 selects wdata[7:0].
    typedef struct packed {
        logic                      we;
        logic [DEFAULT_ADDR_W-1:0] addr;
        logic [NUM_LANES-1:0]      wmask;
        logic [DEFAULT_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/cpu86_mem_arb_grant.sv
// Grant and ready logic for the fetch/data arbiter, including the data burst limit.
// With CPU86_MEM_ARB_DUAL_ISSUE_EN a data write and a non-colliding fetch issue together.
module cpu86_mem_arb_grant
    import cpu86_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W         = DEFAULT_ADDR_W,
    parameter int unsigned MAX_DATA_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    input  logic              d_req_valid,
    input  logic              d_req_we,
    input  logic [ADDR_W-1:0] d_req_addr,
    output logic              if_req_ready,
    output logic              d_req_ready
);

    localparam logic [3:0] BURST_MAX = 4'(MAX_DATA_BURST);

    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic       fetch_starved;
    logic       dual_write;
    logic       addr_hit;

`ifdef CPU86_MEM_ARB_DUAL_ISSUE_EN
    assign dual_write = d_req_we;
    assign addr_hit   = (if_req_addr == d_req_addr);
`else
    logic unused_dual;
    assign dual_write  = 1'b0;
    assign addr_hit    = 1'b0;
    assign unused_dual = ^{d_req_we, if_req_addr, d_req_addr};
`endif

    assign fetch_starved = (burst_cnt_q == BURST_MAX);

    always_comb begin
        if_req_ready = 1'b0;
        d_req_ready  = 1'b0;
        if (!rst) begin
            if (if_req_valid && d_req_valid) begin
                if (dual_write) begin
                    // Same-address fetch waits a cycle so it observes the new data.
                    d_req_ready  = 1'b1;
                    if_req_ready = !addr_hit;
                end else if (fetch_starved) begin
                    if_req_ready = 1'b1;
                end else begin
                    d_req_ready = 1'b1;
                end
            end else begin
                if_req_ready = if_req_valid;
                d_req_ready  = d_req_valid;
            end
        end
    end

    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (!if_req_valid || if_req_ready) begin
            burst_cnt_d = '0;
        end else if (d_req_ready && !fetch_starved) begin
            burst_cnt_d = burst_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt_q <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: rtl/cpu86_mem_arbiter.sv
// Shares the memory core's write and read ports between instruction fetch and data.
// Define CPU86_MEM_ARB_DUAL_ISSUE_EN to let a data write and a fetch read issue together.
module cpu86_mem_arbiter
    import cpu86_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W         = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W         = DEFAULT_DATA_W,
    parameter int unsigned MAX_DATA_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_req_we,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [3:0]        d_req_wmask,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_data,
    output logic              mem_we,
    output logic [3:0]        mem_wmask,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_q
);

    logic if_rd_fire, d_fire, d_wr_fire, d_rd_fire;

    mem_req_t          wr_q, wr_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    rsp_tag_t          tag1_q, tag1_d, tag2_q;

    cpu86_mem_arb_grant #(
        .ADDR_W         (ADDR_W),
        .MAX_DATA_BURST (MAX_DATA_BURST)
    ) u_grant (
        .clk          (clk),
        .rst          (rst),
        .if_req_valid (if_req_valid),
        .if_req_addr  (if_req_addr),
        .d_req_valid  (d_req_valid),
        .d_req_we     (d_req_we),
        .d_req_addr   (d_req_addr),
        .if_req_ready (if_req_ready),
        .d_req_ready  (d_req_ready)
    );

    assign if_rd_fire = if_req_valid && if_req_ready;
    assign d_fire     = d_req_valid && d_req_ready;
    assign d_wr_fire  = d_fire && d_req_we;
    assign d_rd_fire  = d_fire && !d_req_we;

    always_comb begin
        wr_d    = wr_q;
        wr_d.we = 1'b0;
        if (d_wr_fire) begin
            wr_d.we    = 1'b1;
            wr_d.addr  = d_req_addr;
            wr_d.wmask = d_req_wmask;
            wr_d.wdata = d_req_wdata;
        end
        raddr_d = raddr_q;
        tag1_d  = TAG_NONE;
        // At most one read is granted per cycle, so the two cases never overlap.
        if (if_rd_fire) begin
            raddr_d = if_req_addr;
            tag1_d  = TAG_IF;
        end else if (d_rd_fire) begin
            raddr_d = d_req_addr;
            tag1_d  = TAG_D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            raddr_q <= '0;
            tag1_q  <= TAG_NONE;
            tag2_q  <= TAG_NONE;
        end else begin
            wr_q    <= wr_d;
            raddr_q <= raddr_d;
            tag1_q  <= tag1_d;
            tag2_q  <= tag1_q;
        end
    end

    assign mem_we    = wr_q.we;
    assign mem_wmask = wr_q.wmask;
    assign mem_waddr = wr_q.addr;
    assign mem_wdata = wr_q.wdata;
    assign mem_raddr = raddr_q;

    // Gated by rst so a read in flight when reset arrives never responds.
    assign if_rsp_valid = !rst && (tag2_q == TAG_IF);
    assign d_rsp_valid  = !rst && (tag2_q == TAG_D);
    assign if_rsp_data  = if_rsp_valid ? mem_q : '0;
    assign d_rsp_data   = d_rsp_valid ? mem_q : '0;

endmodule

// File: tb/tb_cpu86_mem_arbiter.sv
// Self-checking bench for cpu86_mem_arbiter: directed steps plus random traffic,
// checked every cycle against a transaction-level model and a behavioural memory core.
module tb_cpu86_mem_arbiter;

    localparam int ADDR_W    = 25;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 4;
    localparam int MEM_WORDS = 256;
`ifdef CPU86_MEM_ARB_DUAL_ISSUE_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req_valid, if_req_ready;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_rsp_valid;
    logic [DATA_W-1:0] if_rsp_data;
    logic              d_req_valid, d_req_ready, d_req_we;
    logic [ADDR_W-1:0] d_req_addr;
    logic [3:0]        d_req_wmask;
    logic [DATA_W-1:0] d_req_wdata;
    logic              d_rsp_valid;
    logic [DATA_W-1:0] d_rsp_data;
    logic              mem_we;
    logic [3:0]        mem_wmask;
    logic [ADDR_W-1:0] mem_waddr, mem_raddr;
    logic [DATA_W-1:0] mem_wdata, mem_q;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu86_mem_arbiter #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .MAX_DATA_BURST (MAX_BURST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_req_addr  (if_req_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .d_req_valid  (d_req_valid),
        .d_req_ready  (d_req_ready),
        .d_req_we     (d_req_we),
        .d_req_addr   (d_req_addr),
        .d_req_wmask  (d_req_wmask),
        .d_req_wdata  (d_req_wdata),
        .d_rsp_valid  (d_rsp_valid),
        .d_rsp_data   (d_rsp_data),
        .mem_we       (mem_we),
        .mem_wmask    (mem_wmask),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .mem_raddr    (mem_raddr),
        .mem_q        (mem_q)
    );

    function automatic logic [31:0] init_word(int i);
        logic [7:0] b;
        b = i[7:0];
        if (i >= 16 && i <= 18) return 32'hA0A1A2A3 + 32'(i - 16) * 32'h04040404;
        return {b, 8'h5A, ~b, 8'hC3};
    endfunction

    // Active-low lane mask; mask bit 3 guards byte [7:0], bit 0 guards [31:24].
    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (!m[3-k]) r[8*k +: 8] = wd[8*k +: 8];
        return r;
    endfunction

    // Behavioural core: registered read, write commits at the clock edge.
    logic [31:0] core_mem [MEM_WORDS];
    initial for (int i = 0; i < MEM_WORDS; i++) core_mem[i] <= init_word(i);
    always @(posedge clk) begin
        if (mem_we) core_mem[mem_waddr[7:0]] <= merge(core_mem[mem_waddr[7:0]], mem_wdata,
                                                      mem_wmask);
        mem_q <= core_mem[mem_raddr[7:0]];
    end

    // Transaction-level reference model.
    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;
    rsp_t              if_exp[$];
    rsp_t              d_exp[$];
    logic [31:0]       ref_mem [MEM_WORDS];
    int                cyc = 0;
    int                burst = 0;
    logic              exp_we = 1'b0;
    logic [3:0]        exp_wmask = '0;
    logic [ADDR_W-1:0] exp_waddr = '0, exp_raddr = '0;
    logic [31:0]       exp_wdata = '0;
    int                if_grants = 0;
    bit                both_acc = 1'b0;
    logic [31:0]       last_if_rsp = '0, last_d_rsp = '0;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit          e_ifr, e_dr, both, e_v, act_if, act_d;
        logic        n_we;
        logic [3:0]  n_wmask;
        logic [ADDR_W-1:0] n_waddr, n_raddr;
        logic [31:0] n_wdata;
        rsp_t        r;
        @(negedge clk);
        e_ifr = 1'b0;
        e_dr  = 1'b0;
        if (!rst) begin
            both = if_req_valid && d_req_valid;
            if (both && DUAL && d_req_we) begin
                e_dr  = 1'b1;
                e_ifr = (if_req_addr != d_req_addr);
            end else if (both) begin
                if (burst == MAX_BURST) e_ifr = 1'b1;
                else e_dr = 1'b1;
            end else begin
                e_ifr = if_req_valid;
                e_dr  = d_req_valid;
            end
        end else begin
            if_exp.delete();
            d_exp.delete();
        end
        check("if_req_ready", if_req_ready, e_ifr);
        check("d_req_ready", d_req_ready, e_dr);
        check("mem_we", mem_we, exp_we);
        if (exp_we) begin
            check("mem_waddr", mem_waddr, exp_waddr);
            check("mem_wmask", mem_wmask, exp_wmask);
            check("mem_wdata", mem_wdata, exp_wdata);
        end
        check("mem_raddr", mem_raddr, exp_raddr);

        e_v = (if_exp.size() > 0) && (if_exp[0].due == cyc);
        check("if_rsp_valid", if_rsp_valid, e_v);
        if (e_v) begin
            r = if_exp.pop_front();
            check("if_rsp_data", if_rsp_data, r.data);
        end
        e_v = (d_exp.size() > 0) && (d_exp[0].due == cyc);
        check("d_rsp_valid", d_rsp_valid, e_v);
        if (e_v) begin
            r = d_exp.pop_front();
            check("d_rsp_data", d_rsp_data, r.data);
        end
        if (if_rsp_valid) last_if_rsp = if_rsp_data;
        if (d_rsp_valid) last_d_rsp = d_rsp_data;

        // Model next state.
        n_we = 1'b0;
        n_wmask = exp_wmask;
        n_waddr = exp_waddr;
        n_wdata = exp_wdata;
        n_raddr = exp_raddr;
        if (e_ifr) begin
            if_exp.push_back('{due: cyc + 2, data: ref_mem[if_req_addr[7:0]]});
            n_raddr = if_req_addr;
        end
        if (e_dr && !d_req_we) begin
            d_exp.push_back('{due: cyc + 2, data: ref_mem[d_req_addr[7:0]]});
            n_raddr = d_req_addr;
        end
        if (e_dr && d_req_we) begin
            ref_mem[d_req_addr[7:0]] = merge(ref_mem[d_req_addr[7:0]], d_req_wdata, d_req_wmask);
            n_we = 1'b1;
            n_wmask = d_req_wmask;
            n_waddr = d_req_addr;
            n_wdata = d_req_wdata;
        end
        if (!if_req_valid || e_ifr) burst = 0;
        else if (e_dr && burst < MAX_BURST) burst++;
        if (rst) begin
            burst = 0;
            n_we = 1'b0;
            n_wmask = '0;
            n_waddr = '0;
            n_wdata = '0;
            n_raddr = '0;
        end

        act_if = if_req_valid && if_req_ready;
        act_d  = d_req_valid && d_req_ready;
        both_acc = act_if && act_d;
        if (act_if) if_grants++;

        @(posedge clk);
        #1;
        cyc++;
        exp_we = n_we;
        exp_wmask = n_wmask;
        exp_waddr = n_waddr;
        exp_wdata = n_wdata;
        exp_raddr = n_raddr;
        if (act_if) if_req_valid = 1'b0;
        if (act_d) d_req_valid = 1'b0;
    endtask

    task automatic drain(int max_cycles);
        int n = 0;
        while ((if_req_valid || d_req_valid) && n < max_cycles) begin
            tick();
            n++;
        end
        check("drain_timeout", if_req_valid || d_req_valid, 1'b0);
        repeat (3) tick();
    endtask

    task automatic put_d(logic we, logic [ADDR_W-1:0] a, logic [3:0] m, logic [31:0] wd);
        d_req_valid = 1'b1;
        d_req_we    = we;
        d_req_addr  = a;
        d_req_wmask = m;
        d_req_wdata = wd;
    endtask

    task automatic put_if(logic [ADDR_W-1:0] a);
        if_req_valid = 1'b1;
        if_req_addr  = a;
    endtask

    initial begin
        logic [31:0] w20, want;
        rst = 1'b1;
        if_req_valid = 1'b0;
        if_req_addr = '0;
        d_req_valid = 1'b0;
        d_req_we = 1'b0;
        d_req_addr = '0;
        d_req_wmask = '0;
        d_req_wdata = '0;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
        tick();
        tick();
        check("rst_if_rsp_data", if_rsp_data, 32'h0);
        check("rst_d_rsp_data", d_rsp_data, 32'h0);
        rst = 1'b0;

        // Back-to-back fetches of 0x10..0x12.
        for (int i = 0; i < 3; i++) begin
            put_if(ADDR_W'(16 + i));
            tick();
        end
        drain(10);
        check("fetch_0x12_data", last_if_rsp, 32'hA8A9AAAB);

        // Write then read of 0x20, then an all-lanes-masked write.
        w20 = init_word(32);
        put_d(1'b1, 25'h20, 4'b0110, 32'h11223344);
        tick();
        put_d(1'b0, 25'h20, 4'h0, 32'h0);
        tick();
        drain(10);
        want = {8'h11, w20[23:8], 8'h44};
        check("wr_rd_0x20", last_d_rsp, want);
        put_d(1'b1, 25'h21, 4'hF, 32'hDEADBEEF);
        tick();
        drain(10);

        // Both ports saturated: D,D,D,D,IF repeating.
        if_grants = 0;
        for (int i = 0; i < 15; i++) begin
            if (!if_req_valid) put_if(ADDR_W'($urandom_range(0, 63)));
            if (!d_req_valid) put_d(1'b0, ADDR_W'($urandom_range(0, 63)), 4'h0, 32'h0);
            tick();
        end
        check("burst_if_grants", if_grants, 3);
        drain(20);

        // Reset with two reads in flight.
        put_if(25'h10);
        tick();
        put_d(1'b0, 25'h11, 4'h0, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("post_rst_if_rsp_valid", if_rsp_valid, 1'b0);
        check("post_rst_d_rsp_valid", d_rsp_valid, 1'b0);
        check("post_rst_mem_we", mem_we, 1'b0);
        check("post_rst_mem_raddr", mem_raddr, 25'h0);
        check("post_rst_d_rsp_data", d_rsp_data, 32'h0);
        repeat (3) tick();

        // Write plus fetch, different then equal addresses.
        put_d(1'b1, 25'h30, 4'h0, 32'hCAFEF00D);
        put_if(25'h31);
        tick();
        check("dual_diff_both", both_acc, DUAL);
        drain(10);
        put_d(1'b1, 25'h30, 4'h0, 32'h0BADC0DE);
        put_if(25'h30);
        tick();
        check("dual_same_both", both_acc, 1'b0);
        drain(10);
        check("dual_same_fetch", last_if_rsp, 32'h0BADC0DE);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            if (!if_req_valid && $urandom_range(0, 3) != 0) put_if(ADDR_W'($urandom_range(0, 15)));
            if (!d_req_valid && $urandom_range(0, 3) != 0)
                put_d(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), $urandom);
            tick();
        end
        drain(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
